// File: rtl/dmem_lsu_pkg.sv
// dmem_lsu_pkg: shared encodings for the DMEM load/store unit.
//   - SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILL : req_size encodings
//   - state_t                        : LSU FSM states (IDLE/RD/WR/RESP)
//   - lane_extend()                  : sign/zero-extend right-aligned lane data
package dmem_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  // shifted: target lane already moved down to bit 0.
  function automatic logic [31:0] lane_extend(input logic [31:0] shifted,
                                              input logic [1:0]  size,
                                              input logic        uns);
    logic [31:0] r;
    case (size)
      SZ_BYTE: r = {{24{~uns & shifted[7]}},  shifted[7:0]};
      SZ_HALF: r = {{16{~uns & shifted[15]}}, shifted[15:0]};
      default: r = shifted;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// dmem_lsu_align: combinational lane handling for the LSU.
//   size/uns/lane : registered request size, unsigned flag, byte address [1:0]
//   rword         : word read from DMEM
//   wdata         : right-aligned store data
//   ldata         : extracted + extended load data
//   mword         : rword with the target lane(s) replaced by wdata
module dmem_lsu_align
  import dmem_lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [1:0]  lane,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic [31:0] mword
);

  logic [4:0] sh;
  assign sh    = {lane, 3'b000};
  assign ldata = lane_extend(rword >> sh, size, uns);

  always_comb begin
    mword = rword;
    case (size)
      SZ_BYTE: mword[sh +: 8] = wdata[7:0];
      // lane[0] is already cleared for halves, so sh is 0 or 16
      SZ_HALF: mword[sh +: 16] = wdata[15:0];
      default: mword = wdata;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store initiator for the word-wide DMEM.
//   Request side : req_valid/req_ready handshake, req_we, req_size, req_unsigned,
//                  req_addr (byte address), req_wdata (right-aligned)
//   Response side: resp_valid (1-cycle pulse), resp_rdata, resp_err
//   DMEM side    : dmem_ena, dmem_wena, dmem_addr (word), dmem_wdata, dmem_rdata
// Sub-word stores do read-modify-write (RD then WR). Illegal size always errors.
// Config macro LSU_MISALIGN_TRAP_EN: misaligned half/word -> error without DMEM
// access; when undefined, offending low address bits are cleared instead.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              dmem_ena,
  output logic              dmem_wena,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata
);

  state_t            state, state_nx;
  logic              r_we, r_uns;
  logic [1:0]        r_size;
  logic [ADDR_W+1:0] r_addr;
  logic [31:0]       wr_word;   // store data, then merged word for RMW
  logic [31:0]       ldata, mword;

  logic              accept, size_err, misalign, err_in;
  logic [ADDR_W+1:0] addr_in;

  assign accept   = req_valid && (state == IDLE);
  assign size_err = (req_size == SZ_ILL);
  assign misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                    ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

`ifdef LSU_MISALIGN_TRAP_EN
  assign err_in  = size_err || misalign;
  assign addr_in = req_addr;
`else
  assign err_in = size_err;
  always_comb begin
    addr_in = req_addr;
    if (req_size == SZ_HALF) addr_in[0]   = 1'b0;
    if (req_size == SZ_WORD) addr_in[1:0] = 2'b00;
  end
`endif

  dmem_lsu_align u_align (
    .size  (r_size),
    .uns   (r_uns),
    .lane  (r_addr[1:0]),
    .rword (dmem_rdata),
    .wdata (wr_word),
    .ldata (ldata),
    .mword (mword)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      r_we       <= 1'b0;
      r_uns      <= 1'b0;
      r_size     <= SZ_BYTE;
      r_addr     <= '0;
      wr_word    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        r_we       <= req_we;
        r_uns      <= req_unsigned;
        r_size     <= req_size;
        r_addr     <= addr_in;
        wr_word    <= req_wdata;
        resp_rdata <= '0;
        resp_err   <= err_in;
      end
      if (state == RD) begin
        if (r_we) wr_word    <= mword;
        else      resp_rdata <= ldata;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (req_valid) begin
        if (err_in)                            state_nx = RESP;
        else if (!req_we || req_size != SZ_WORD) state_nx = RD;
        else                                   state_nx = WR;
      end
      RD:   state_nx = r_we ? WR : RESP;
      WR:   state_nx = RESP;
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign dmem_ena   = (state == RD) || (state == WR);
  assign dmem_wena  = (state == WR);
  assign dmem_addr  = r_addr[ADDR_W+1:2];
  assign dmem_wdata = wr_word;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed self-checking bench for dmem_lsu with a simple
// combinational-read / synchronous-write DMEM model. Honours LSU_MISALIGN_TRAP_EN.
module tb_dmem_lsu;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]        req_size = 2'b00;
  logic [ADDR_W+1:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              req_ready, resp_valid, resp_err, dmem_ena, dmem_wena;
  logic [31:0]       resp_rdata, dmem_wdata, dmem_rdata;
  logic [ADDR_W-1:0] dmem_addr;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (dmem_ena && dmem_wena) mem[dmem_addr] <= dmem_wdata;
  assign dmem_rdata = mem[dmem_addr];

  dmem_lsu #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dmem_ena(dmem_ena), .dmem_wena(dmem_wena), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request; sample every negedge after the accepting edge.
  task automatic txn(input logic we, input logic [1:0] size, input logic uns,
                     input logic [ADDR_W+1:0] addr, input logic [31:0] wd,
                     output logic [31:0] rdata, output logic err, output int lat,
                     output int wcnt, output int ecnt, output logic [ADDR_W-1:0] waddr);
    logic done;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 0; wcnt = 0; ecnt = 0; done = 1'b0; rdata = 'x; err = 1'bx; waddr = '0;
    while (!done && lat < 8) begin
      @(negedge clk);
      lat++;
      if (dmem_ena) ecnt++;
      if (dmem_ena && dmem_wena) begin wcnt++; waddr = dmem_addr; end
      if (resp_valid) begin done = 1'b1; rdata = resp_rdata; err = resp_err; end
    end
    if (!done) check("resp_timeout", 32'd0, 32'd1);
  endtask

  logic [31:0]       rd;
  logic              er;
  int                lat, wc, ec, n;
  logic [ADDR_W-1:0] wa;

  initial begin
    // reset state
    #12;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_outs", {26'd0, resp_valid, resp_err, dmem_ena, dmem_wena, 2'b00}, 32'd0);
    check("rst_addr_wdata", {dmem_addr, 27'd0} | dmem_wdata | resp_rdata, 32'd0);
    @(negedge clk); rst = 1'b0;

    // pre-initialise words used later
    txn(1, 2'b10, 0, 7'h10, 32'h0, rd, er, lat, wc, ec, wa);
    txn(1, 2'b10, 0, 7'h7C, 32'h0, rd, er, lat, wc, ec, wa);

    // word store + word load
    txn(1, 2'b10, 0, 7'h08, 32'h12345678, rd, er, lat, wc, ec, wa);
    check("sw_lat", lat, 2);
    check("sw_wcnt", wc, 1);
    check("sw_waddr", {27'd0, wa}, 32'd2);
    check("sw_mem", mem[2], 32'h12345678);
    txn(0, 2'b10, 0, 7'h08, 32'h0, rd, er, lat, wc, ec, wa);
    check("lw_lat", lat, 2);
    check("lw_data", rd, 32'h12345678);
    check("lw_wcnt", wc, 0);

    // reset during RD of a load
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 7'h08;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    check("mid_rd_ena", {31'd0, dmem_ena}, 32'd1);
    rst = 1'b1; #1;
    check("mid_rst_outs", {26'd0, req_ready, resp_valid, resp_err, dmem_ena, dmem_wena, 1'b0}, 32'h20);
    check("mid_rst_data", resp_rdata | dmem_wdata | {27'd0, dmem_addr}, 32'd0);
    n = 0;
    repeat (2) begin @(negedge clk); if (resp_valid) n++; end
    rst = 1'b0;
    repeat (2) begin @(negedge clk); if (resp_valid) n++; end
    check("mid_rst_noresp", n, 0);
    check("mid_rst_mem", mem[2], 32'h12345678);

    // byte store read-modify-write
    txn(1, 2'b00, 0, 7'h09, 32'hFFFFFFAB, rd, er, lat, wc, ec, wa);
    check("sb_lat", lat, 3);
    check("sb_wcnt", wc, 1);
    check("sb_waddr", {27'd0, wa}, 32'd2);
    check("sb_mem", mem[2], 32'h1234AB78);
    check("sb_rdata", rd, 32'd0);

    // extension
    txn(1, 2'b10, 0, 7'h0C, 32'h8000FF80, rd, er, lat, wc, ec, wa);
    txn(0, 2'b00, 0, 7'h0C, 32'h0, rd, er, lat, wc, ec, wa);
    check("lb", rd, 32'hFFFFFF80);
    txn(0, 2'b00, 1, 7'h0C, 32'h0, rd, er, lat, wc, ec, wa);
    check("lbu", rd, 32'h00000080);
    txn(0, 2'b01, 0, 7'h0E, 32'h0, rd, er, lat, wc, ec, wa);
    check("lh", rd, 32'hFFFF8000);
    txn(0, 2'b01, 1, 7'h0E, 32'h0, rd, er, lat, wc, ec, wa);
    check("lhu", rd, 32'h00008000);
    txn(0, 2'b00, 1, 7'h0D, 32'h0, rd, er, lat, wc, ec, wa);
    check("lbu_lane1", rd, 32'h000000FF);

    // misaligned half load
    txn(1, 2'b10, 0, 7'h04, 32'hCAFE8001, rd, er, lat, wc, ec, wa);
    txn(0, 2'b01, 0, 7'h05, 32'h0, rd, er, lat, wc, ec, wa);
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_err", {31'd0, er}, 32'd1);
    check("mis_lat", lat, 1);
    check("mis_ena", ec, 0);
    check("mis_rdata", rd, 32'd0);
`else
    check("mis_err", {31'd0, er}, 32'd0);
    check("mis_lat", lat, 2);
    check("mis_rdata", rd, 32'hFFFF8001);
`endif

    // illegal size
    txn(1, 2'b11, 0, 7'h08, 32'hDEADBEEF, rd, er, lat, wc, ec, wa);
    check("ill_err", {31'd0, er}, 32'd1);
    check("ill_lat", lat, 1);
    check("ill_noacc", ec, 0);
    check("ill_mem", mem[2], 32'h1234AB78);

    // back-to-back with req_valid held, second store wraps to word 31
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 7'h10; req_wdata = 32'h5A;
    n = 0;
    while (!resp_valid && n < 8) begin @(negedge clk); n++; end
    check("b2b_first_lat", n, 3);
    req_addr = 7'h7F; req_wdata = 32'hEE;
    check("b2b_resp_notready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check("b2b_ready_after_resp", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_second_rd", {29'd0, dmem_ena, dmem_wena, 1'b0}, 32'd4);
    check("b2b_wrap_addr", {27'd0, dmem_addr}, 32'd31);
    n = 0;
    while (!resp_valid && n < 8) begin @(negedge clk); n++; end
    check("b2b_second_lat", n, 2);
    check("b2b_mem4", mem[4], 32'h0000005A);
    check("b2b_mem31", mem[31], 32'hEE000000);

    @(negedge clk);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
